// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus for the ID/EX pipeline register.
// The master side is the ID/EX stage: it consumes the decode fields and
// drives the execute-stage inputs plus the IF/ID stall request.
interface id_ex_stage_if #(
    parameter int DW = 16,
    parameter int RW = 3
);
    // Decode-side fields
    logic          id_valid;
    logic [DW-1:0] id_PC2;
    logic [DW-1:0] id_Rd1;
    logic [DW-1:0] id_Rd2;
    logic [DW-1:0] id_Imm;
    logic [4:0]    id_ALUOp;
    logic [1:0]    id_ALUF;
    logic          id_ALUSrc;
    logic          id_Branch;
    logic          id_Jump;
    logic          id_MemRead;
    logic          id_MemWrite;
    logic          id_RegWrite;
    logic [RW-1:0] id_WrReg;
    logic [RW-1:0] id_RsReg;
    logic [RW-1:0] id_RtReg;
    logic          id_RsUsed;
    logic          id_RtUsed;
    logic          id_err;

    // Execute-side fields
    logic          ex_valid;
    logic [DW-1:0] ex_PC2;
    logic [DW-1:0] ex_Rd1;
    logic [DW-1:0] ex_Rd2;
    logic [DW-1:0] ex_Imm;
    logic [4:0]    ex_ALUOp;
    logic [1:0]    ex_ALUF;
    logic          ex_ALUSrc;
    logic          ex_Branch;
    logic          ex_Jump;
    logic          ex_MemRead;
    logic          ex_MemWrite;
    logic          ex_RegWrite;
    logic [RW-1:0] ex_WrReg;
    logic          stall_id;
    logic          err;

    modport master (
        input  id_valid, id_PC2, id_Rd1, id_Rd2, id_Imm, id_ALUOp, id_ALUF,
               id_ALUSrc, id_Branch, id_Jump, id_MemRead, id_MemWrite,
               id_RegWrite, id_WrReg, id_RsReg, id_RtReg, id_RsUsed,
               id_RtUsed, id_err,
        output ex_valid, ex_PC2, ex_Rd1, ex_Rd2, ex_Imm, ex_ALUOp, ex_ALUF,
               ex_ALUSrc, ex_Branch, ex_Jump, ex_MemRead, ex_MemWrite,
               ex_RegWrite, ex_WrReg, stall_id, err
    );

    modport slave (
        output id_valid, id_PC2, id_Rd1, id_Rd2, id_Imm, id_ALUOp, id_ALUF,
               id_ALUSrc, id_Branch, id_Jump, id_MemRead, id_MemWrite,
               id_RegWrite, id_WrReg, id_RsReg, id_RtReg, id_RsUsed,
               id_RtUsed, id_err,
        input  ex_valid, ex_PC2, ex_Rd1, ex_Rd2, ex_Imm, ex_ALUOp, ex_ALUF,
               ex_ALUSrc, ex_Branch, ex_Jump, ex_MemRead, ex_MemWrite,
               ex_RegWrite, ex_WrReg, stall_id, err
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit five-stage core.
// Latches decode outputs, forwards EX/MEM and MEM/WB results onto the
// latched operands, and inserts a bubble on a load-use hazard.
module id_ex_stage #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.master bus,
    input  logic          exm_RegWrite,
    input  logic          exm_MemRead,
    input  logic [RW-1:0] exm_WrReg,
    input  logic [DW-1:0] exm_ALUO,
    input  logic          mwb_RegWrite,
    input  logic [RW-1:0] mwb_WrReg,
    input  logic [DW-1:0] mwb_WrData,
    input  logic          flush,
    input  logic          mem_stall
);

    // All state of one in-flight instruction; an all-zero value is a bubble.
    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc2;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [4:0]    aluop;
        logic [1:0]    aluf;
        logic          alusrc;
        logic          branch;
        logic          jump;
        logic          memread;
        logic          memwrite;
        logic          regwrite;
        logic [RW-1:0] wrreg;
        logic [RW-1:0] rsreg;
        logic [RW-1:0] rtreg;
        logic          rsused;
        logic          rtused;
        logic          err;
    } stage_t;

    stage_t st_p0;
    stage_t id_fields;
    logic   load_use;

    // Operand bypass: a non-load EX/MEM result wins over MEM/WB, otherwise the
    // latched register-file value is used. Loads in EX/MEM are never bypassed;
    // the hazard bubble delays the consumer until the data sits in MEM/WB.
    function automatic logic [DW-1:0] fwd(
        input logic          used,
        input logic [RW-1:0] src,
        input logic [DW-1:0] latched,
        input logic          x_regwrite,
        input logic          x_memread,
        input logic [RW-1:0] x_wrreg,
        input logic [DW-1:0] x_data,
        input logic          w_regwrite,
        input logic [RW-1:0] w_wrreg,
        input logic [DW-1:0] w_data
    );
        if (used && x_regwrite && !x_memread && (x_wrreg == src))
            return x_data;
        else if (used && w_regwrite && (w_wrreg == src))
            return w_data;
        else
            return latched;
    endfunction

    // Gather the decode fields into one record for the normal load.
    always_comb begin
        id_fields          = '0;
        id_fields.valid    = bus.id_valid;
        id_fields.pc2      = bus.id_PC2;
        id_fields.rd1      = bus.id_Rd1;
        id_fields.rd2      = bus.id_Rd2;
        id_fields.imm      = bus.id_Imm;
        id_fields.aluop    = bus.id_ALUOp;
        id_fields.aluf     = bus.id_ALUF;
        id_fields.alusrc   = bus.id_ALUSrc;
        id_fields.branch   = bus.id_Branch;
        id_fields.jump     = bus.id_Jump;
        id_fields.memread  = bus.id_MemRead;
        id_fields.memwrite = bus.id_MemWrite;
        id_fields.regwrite = bus.id_RegWrite;
        id_fields.wrreg    = bus.id_WrReg;
        id_fields.rsreg    = bus.id_RsReg;
        id_fields.rtreg    = bus.id_RtReg;
        id_fields.rsused   = bus.id_RsUsed;
        id_fields.rtused   = bus.id_RtUsed;
        id_fields.err      = bus.id_err;
    end

    // Load-use hazard: a load in EX targets a register the decoding instruction reads.
    always_comb begin
        load_use = st_p0.valid && st_p0.memread && st_p0.regwrite && bus.id_valid &&
                   ((bus.id_RsUsed && (bus.id_RsReg == st_p0.wrreg)) ||
                    (bus.id_RtUsed && (bus.id_RtReg == st_p0.wrreg)));
    end

    // Pipeline register update, priority rst > flush > mem_stall > load_use > normal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            st_p0 <= '0;
        else if (flush)
            st_p0 <= '0;
        else if (mem_stall)
            st_p0 <= st_p0;
        else if (load_use)
            st_p0 <= '0;
        else
            st_p0 <= id_fields;
    end

    // ---- p0 stage boundary: execute-side outputs ----
    // IF/ID squashes itself on a flush, so it must not be frozen then.
    assign bus.stall_id    = !flush && (mem_stall || load_use);
    assign bus.err         = st_p0.valid && st_p0.err;
    assign bus.ex_valid    = st_p0.valid;
    assign bus.ex_PC2      = st_p0.pc2;
    assign bus.ex_Imm      = st_p0.imm;
    assign bus.ex_ALUOp    = st_p0.aluop;
    assign bus.ex_ALUF     = st_p0.aluf;
    assign bus.ex_ALUSrc   = st_p0.alusrc;
    assign bus.ex_Branch   = st_p0.branch;
    assign bus.ex_Jump     = st_p0.jump;
    assign bus.ex_MemRead  = st_p0.memread;
    assign bus.ex_MemWrite = st_p0.memwrite;
    assign bus.ex_RegWrite = st_p0.regwrite;
    assign bus.ex_WrReg    = st_p0.wrreg;
    assign bus.ex_Rd1 = fwd(st_p0.rsused, st_p0.rsreg, st_p0.rd1,
                            exm_RegWrite, exm_MemRead, exm_WrReg, exm_ALUO,
                            mwb_RegWrite, mwb_WrReg, mwb_WrData);
    assign bus.ex_Rd2 = fwd(st_p0.rtused, st_p0.rtreg, st_p0.rd2,
                            exm_RegWrite, exm_MemRead, exm_WrReg, exm_ALUO,
                            mwb_RegWrite, mwb_WrReg, mwb_WrData);

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for the ID/EX pipeline register.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exm_RegWrite, exm_MemRead;
    logic [2:0]  exm_WrReg;
    logic [15:0] exm_ALUO;
    logic        mwb_RegWrite;
    logic [2:0]  mwb_WrReg;
    logic [15:0] mwb_WrData;
    logic        flush, mem_stall;

    int total = 0;
    int bad   = 0;

    id_ex_stage_if #(.DW(16), .RW(3)) bus ();

    id_ex_stage #(.DW(16), .RW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .exm_RegWrite (exm_RegWrite),
        .exm_MemRead  (exm_MemRead),
        .exm_WrReg    (exm_WrReg),
        .exm_ALUO     (exm_ALUO),
        .mwb_RegWrite (mwb_RegWrite),
        .mwb_WrReg    (mwb_WrReg),
        .mwb_WrData   (mwb_WrData),
        .flush        (flush),
        .mem_stall    (mem_stall)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid = 0; bus.id_PC2 = 0; bus.id_Rd1 = 0; bus.id_Rd2 = 0;
        bus.id_Imm = 0; bus.id_ALUOp = 0; bus.id_ALUF = 0; bus.id_ALUSrc = 0;
        bus.id_Branch = 0; bus.id_Jump = 0; bus.id_MemRead = 0;
        bus.id_MemWrite = 0; bus.id_RegWrite = 0; bus.id_WrReg = 0;
        bus.id_RsReg = 0; bus.id_RtReg = 0; bus.id_RsUsed = 0;
        bus.id_RtUsed = 0; bus.id_err = 0;
        exm_RegWrite = 0; exm_MemRead = 0; exm_WrReg = 0; exm_ALUO = 0;
        mwb_RegWrite = 0; mwb_WrReg = 0; mwb_WrData = 0;
        flush = 0; mem_stall = 0;
    endtask

    task automatic test_reset();
        logic [86:0] outs;
        clear_inputs();
        rst = 1;
        #2;
        outs = {bus.ex_valid, bus.ex_PC2, bus.ex_Rd1, bus.ex_Rd2, bus.ex_Imm,
                bus.ex_ALUOp, bus.ex_ALUF, bus.ex_ALUSrc, bus.ex_Branch,
                bus.ex_Jump, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_RegWrite,
                bus.ex_WrReg, bus.stall_id, bus.err};
        total++;
        if (outs !== '0) begin
            bad++; $display("FAIL reset_initial outs=%h want=0", outs);
        end
        step();
        rst = 0;
        step();
        // load an instruction then reset between edges
        bus.id_valid = 1; bus.id_Rd1 = 16'h1234; bus.id_RegWrite = 1;
        bus.id_PC2 = 16'h0004; bus.id_err = 1;
        step();
        total++;
        if (bus.ex_valid !== 1'b1 || bus.ex_Rd1 !== 16'h1234) begin
            bad++; $display("FAIL reset_preload valid=%b rd1=%h want 1/1234", bus.ex_valid, bus.ex_Rd1);
        end
        #2 rst = 1;
        #1;
        outs = {bus.ex_valid, bus.ex_PC2, bus.ex_Rd1, bus.ex_Rd2, bus.ex_Imm,
                bus.ex_ALUOp, bus.ex_ALUF, bus.ex_ALUSrc, bus.ex_Branch,
                bus.ex_Jump, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_RegWrite,
                bus.ex_WrReg, bus.stall_id, bus.err};
        total++;
        if (outs !== '0) begin
            bad++; $display("FAIL reset_async outs=%h want=0", outs);
        end
        step();
        clear_inputs();
        rst = 0;
        step();
    endtask

    task automatic test_normal();
        clear_inputs();
        bus.id_valid = 1; bus.id_Rd1 = 16'h00A5; bus.id_Imm = 16'hFFF0;
        bus.id_ALUOp = 5'b01000; bus.id_RegWrite = 1; bus.id_PC2 = 16'h0010;
        bus.id_Rd2 = 16'h3C3C; bus.id_ALUF = 2'b10; bus.id_WrReg = 3'd6;
        step();
        total++;
        if (bus.ex_valid !== 1 || bus.ex_Rd1 !== 16'h00A5 || bus.ex_Imm !== 16'hFFF0 ||
            bus.ex_ALUOp !== 5'b01000 || bus.ex_RegWrite !== 1 || bus.ex_PC2 !== 16'h0010) begin
            bad++;
            $display("FAIL normal_latch v=%b rd1=%h imm=%h op=%b rw=%b pc=%h want 1/00a5/fff0/01000/1/0010",
                     bus.ex_valid, bus.ex_Rd1, bus.ex_Imm, bus.ex_ALUOp, bus.ex_RegWrite, bus.ex_PC2);
        end
        total++;
        if (bus.ex_Rd2 !== 16'h3C3C || bus.ex_ALUF !== 2'b10 || bus.ex_WrReg !== 3'd6 ||
            bus.ex_MemRead !== 0 || bus.stall_id !== 0 || bus.err !== 0) begin
            bad++;
            $display("FAIL normal_misc rd2=%h aluf=%b wr=%0d mr=%b stall=%b err=%b want 3c3c/10/6/0/0/0",
                     bus.ex_Rd2, bus.ex_ALUF, bus.ex_WrReg, bus.ex_MemRead, bus.stall_id, bus.err);
        end
    endtask

    task automatic test_forward();
        clear_inputs();
        bus.id_valid = 1; bus.id_RsReg = 3; bus.id_RsUsed = 1; bus.id_Rd1 = 16'h5555;
        bus.id_RtReg = 6; bus.id_RtUsed = 1; bus.id_Rd2 = 16'h6666;
        step();
        exm_RegWrite = 1; exm_WrReg = 3; exm_ALUO = 16'h1111;
        mwb_RegWrite = 1; mwb_WrReg = 3; mwb_WrData = 16'h2222;
        #1;
        total++;
        if (bus.ex_Rd1 !== 16'h1111) begin
            bad++; $display("FAIL fwd_exm_priority rd1=%h want 1111", bus.ex_Rd1);
        end
        total++;
        if (bus.ex_Rd2 !== 16'h6666) begin
            bad++; $display("FAIL fwd_rd2_nomatch rd2=%h want 6666", bus.ex_Rd2);
        end
        exm_RegWrite = 0;
        #1;
        total++;
        if (bus.ex_Rd1 !== 16'h2222) begin
            bad++; $display("FAIL fwd_mwb rd1=%h want 2222", bus.ex_Rd1);
        end
        mwb_RegWrite = 0;
        #1;
        total++;
        if (bus.ex_Rd1 !== 16'h5555) begin
            bad++; $display("FAIL fwd_none rd1=%h want 5555", bus.ex_Rd1);
        end
        exm_RegWrite = 1; exm_MemRead = 1;
        #1;
        total++;
        if (bus.ex_Rd1 !== 16'h5555) begin
            bad++; $display("FAIL fwd_no_load_bypass rd1=%h want 5555", bus.ex_Rd1);
        end
        exm_RegWrite = 0; exm_MemRead = 0;
        mwb_RegWrite = 1; mwb_WrReg = 6; mwb_WrData = 16'h7777;
        #1;
        total++;
        if (bus.ex_Rd2 !== 16'h7777 || bus.ex_Rd1 !== 16'h5555) begin
            bad++; $display("FAIL fwd_rd2_mwb rd2=%h rd1=%h want 7777/5555", bus.ex_Rd2, bus.ex_Rd1);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        // load to R5 enters EX
        bus.id_valid = 1; bus.id_MemRead = 1; bus.id_RegWrite = 1; bus.id_WrReg = 5;
        step();
        // consumer in decode reads R5 through Rt
        clear_inputs();
        bus.id_valid = 1; bus.id_RtUsed = 1; bus.id_RtReg = 5; bus.id_Rd2 = 16'h0BAD;
        bus.id_RegWrite = 1; bus.id_WrReg = 2; bus.id_ALUOp = 5'b00011;
        #1;
        total++;
        if (bus.stall_id !== 1) begin
            bad++; $display("FAIL lu_stall stall_id=%b want 1", bus.stall_id);
        end
        step();
        total++;
        if (bus.ex_valid !== 0 || bus.ex_RegWrite !== 0 || bus.ex_MemRead !== 0 ||
            bus.ex_ALUOp !== 0 || bus.ex_WrReg !== 0) begin
            bad++;
            $display("FAIL lu_bubble v=%b rw=%b mr=%b op=%b wr=%0d want all 0",
                     bus.ex_valid, bus.ex_RegWrite, bus.ex_MemRead, bus.ex_ALUOp, bus.ex_WrReg);
        end
        total++;
        if (bus.stall_id !== 0) begin
            bad++; $display("FAIL lu_stall_release stall_id=%b want 0", bus.stall_id);
        end
        // load now in EX/MEM; consumer latches on this edge
        exm_RegWrite = 1; exm_MemRead = 1; exm_WrReg = 5; exm_ALUO = 16'h0010;
        step();
        exm_RegWrite = 0; exm_MemRead = 0; exm_WrReg = 0;
        mwb_RegWrite = 1; mwb_WrReg = 5; mwb_WrData = 16'hBEEF;
        #1;
        total++;
        if (bus.ex_valid !== 1 || bus.ex_Rd2 !== 16'hBEEF || bus.ex_WrReg !== 3'd2) begin
            bad++;
            $display("FAIL lu_consumer v=%b rd2=%h wr=%0d want 1/beef/2", bus.ex_valid, bus.ex_Rd2, bus.ex_WrReg);
        end
    endtask

    task automatic test_mem_stall();
        clear_inputs();
        bus.id_valid = 1; bus.id_PC2 = 16'h0042; bus.id_Imm = 16'h0007;
        step();
        mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            bus.id_PC2 = 16'h0100 + 16'(i);
            bus.id_Imm = 16'hA000 + 16'(i);
            bus.id_valid = i[0];
            #1;
            total++;
            if (bus.stall_id !== 1) begin
                bad++; $display("FAIL ms_stall_%0d stall_id=%b want 1", i, bus.stall_id);
            end
            step();
            total++;
            if (bus.ex_valid !== 1 || bus.ex_PC2 !== 16'h0042 || bus.ex_Imm !== 16'h0007) begin
                bad++;
                $display("FAIL ms_hold_%0d v=%b pc=%h imm=%h want 1/0042/0007", i, bus.ex_valid, bus.ex_PC2, bus.ex_Imm);
            end
        end
        mem_stall = 0;
        bus.id_valid = 1; bus.id_PC2 = 16'h0077; bus.id_Imm = 16'h0003;
        step();
        total++;
        if (bus.ex_PC2 !== 16'h0077 || bus.ex_Imm !== 16'h0003 || bus.stall_id !== 0) begin
            bad++;
            $display("FAIL ms_release pc=%h imm=%h stall=%b want 0077/0003/0", bus.ex_PC2, bus.ex_Imm, bus.stall_id);
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        bus.id_valid = 1; bus.id_RegWrite = 1; bus.id_Branch = 1; bus.id_Jump = 1; bus.id_err = 1;
        step();
        total++;
        if (bus.err !== 1 || bus.ex_valid !== 1 || bus.ex_Branch !== 1) begin
            bad++; $display("FAIL fl_err_latched err=%b v=%b br=%b want 1/1/1", bus.err, bus.ex_valid, bus.ex_Branch);
        end
        flush = 1; mem_stall = 1;
        #1;
        total++;
        if (bus.stall_id !== 0) begin
            bad++; $display("FAIL fl_stall stall_id=%b want 0", bus.stall_id);
        end
        step();
        total++;
        if (bus.ex_valid !== 0 || bus.ex_RegWrite !== 0 || bus.ex_Branch !== 0 ||
            bus.ex_Jump !== 0 || bus.err !== 0) begin
            bad++;
            $display("FAIL fl_bubble v=%b rw=%b br=%b j=%b err=%b want all 0",
                     bus.ex_valid, bus.ex_RegWrite, bus.ex_Branch, bus.ex_Jump, bus.err);
        end
        // flush together with a load-use hazard
        clear_inputs();
        bus.id_valid = 1; bus.id_MemRead = 1; bus.id_RegWrite = 1; bus.id_WrReg = 4;
        step();
        clear_inputs();
        bus.id_valid = 1; bus.id_RsUsed = 1; bus.id_RsReg = 4; bus.id_RegWrite = 1;
        #1;
        total++;
        if (bus.stall_id !== 1) begin
            bad++; $display("FAIL fl_lu_pre stall_id=%b want 1", bus.stall_id);
        end
        flush = 1;
        #1;
        total++;
        if (bus.stall_id !== 0) begin
            bad++; $display("FAIL fl_lu_stall stall_id=%b want 0", bus.stall_id);
        end
        step();
        total++;
        if (bus.ex_valid !== 0 || bus.ex_RegWrite !== 0 || bus.ex_MemRead !== 0) begin
            bad++; $display("FAIL fl_lu_bubble v=%b rw=%b mr=%b want 0/0/0", bus.ex_valid, bus.ex_RegWrite, bus.ex_MemRead);
        end
        flush = 0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_forward();
        test_load_use();
        test_mem_stall();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
